// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, fetches from imem over req/ack and fills the IF/ID latch; define FETCH_TIMEOUT_EN for the imem watchdog
module fetch_stage #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                IMEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stage_reset_n,
  input  logic              wb_if_wren,
  input  logic              if_id_wren,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic              fetch_busy,
  output logic              fetch_err
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, if_id_pc_q, if_id_pc_d, next_pc;
  logic [31:0] buf_q, buf_d, instr_q, instr_d, rdata_ev;
  logic need_q, need_d, valid_q, valid_d, late_q, late_d, stale_q, stale_d, err_q, err_d;
  logic timeout, ack_ev;
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(IMEM_TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  assign timeout = (state_q == REQ) && (cnt_q == CW'(IMEM_TIMEOUT - 1));
  // Watchdog counts cycles of the current request and restarts on every fresh request
  always_ff @(posedge clk)
    if (!reset_n || !stage_reset_n) cnt_q <= '0;
    else cnt_q <= (state_q == REQ && !ack_ev) ? cnt_q + 1'b1 : '0;
`else
  assign timeout = 1'b0;
`endif
  assign ack_ev   = (state_q == REQ) && (imem_ack || timeout);
  assign rdata_ev = imem_ack ? imem_rdata : NOP;
  assign next_pc  = branch_taken ? {branch_target[ADDR_W-1:2], 2'b00} : pc_q + ADDR_W'(4);
  // Fetch sequencing; a PC writeback is applied last so it can redirect whatever the FSM decided
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    need_d     = need_q;
    buf_d      = buf_q;
    instr_d    = instr_q;
    if_id_pc_d = if_id_pc_q;
    valid_d    = valid_q;
    late_d     = late_q;
    stale_d    = stale_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (need_q) begin
          state_d = REQ;
          need_d  = 1'b0;
        end
        if (if_id_wren) valid_d = 1'b0;
      end
      REQ: begin
        if (if_id_wren) begin
          late_d  = 1'b1;
          valid_d = 1'b0;
        end
        if (timeout && !imem_ack) err_d = 1'b1;
        if (ack_ev) begin
          if (stale_q || wb_if_wren) begin
            stale_d = 1'b0;
            need_d  = 1'b0;
          end else if (late_q || if_id_wren) begin
            instr_d    = rdata_ev;
            if_id_pc_d = pc_q;
            valid_d    = 1'b1;
            late_d     = 1'b0;
            state_d    = IDLE;
          end else begin
            buf_d   = rdata_ev;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (if_id_wren) begin
          instr_d    = buf_q;
          if_id_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wb_if_wren) begin
      pc_d    = next_pc;
      need_d  = !ack_ev && !(state_q == IDLE && need_q);
      stale_d = (state_q == REQ) && !ack_ev;
      if (branch_taken && |branch_target[1:0]) err_d = 1'b1;
      if (state_q == DONE) state_d = IDLE;
    end
  end
  // Fetch state and IF/ID latch; both resets return to the post-reset fetch
  always_ff @(posedge clk)
    if (!reset_n || !stage_reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      need_q     <= 1'b1;
      buf_q      <= NOP;
      instr_q    <= NOP;
      if_id_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      late_q     <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      need_q     <= need_d;
      buf_q      <= buf_d;
      instr_q    <= instr_d;
      if_id_pc_q <= if_id_pc_d;
      valid_q    <= valid_d;
      late_q     <= late_d;
      stale_q    <= stale_d;
    end
  // Sticky error survives soft reset; only the hard reset clears it
  always_ff @(posedge clk)
    if (!reset_n) err_q <= 1'b0;
    else if (stage_reset_n) err_q <= err_d;
  assign imem_req    = state_q == REQ;
  assign fetch_busy  = state_q == REQ;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = instr_q;
  assign if_id_valid = valid_q;
  assign fetch_err   = err_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table, directed corner sequences and a randomized transaction-level model for fetch_stage
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0, stage_reset_n = 1'b1, wb_if_wren = 1'b0, if_id_wren = 1'b0;
  logic        branch_taken = 1'b0, imem_ack = 1'b0;
  logic [31:0] branch_target = '0, imem_rdata = '0;
  logic        imem_req, if_id_valid, fetch_busy, fetch_err;
  logic [31:0] imem_addr, pc_out, if_id_pc, if_id_instr;
  int checks = 0, errors = 0;

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .IMEM_TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .stage_reset_n(stage_reset_n),
    .wb_if_wren(wb_if_wren), .if_id_wren(if_id_wren),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .fetch_busy(fetch_busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [31:0] data;
    logic [31:0] exp_pc;
    logic        exp_err;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!fetch_busy && n < 20) begin
      tick();
      n++;
    end
    chk("wait_busy", {31'b0, fetch_busy}, 32'd1);
  endtask

  task automatic ack(input logic [31:0] d);
    imem_ack = 1'b1;
    imem_rdata = d;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic wb(input logic t, input logic [31:0] tgt);
    wb_if_wren = 1'b1;
    branch_taken = t;
    branch_target = tgt;
    tick();
    wb_if_wren = 1'b0;
    branch_taken = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc_m, old_pc, data, tgt;
    logic        err_m, late, taken, combo;
    int          n;
    vecs[0] = '{1'b1, 32'h0000_0010, 32'h0000_1111, 32'h0000_0010, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0000, 32'h0000_2222, 32'h0000_0014, 1'b0};
    vecs[2] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_3333, 32'hFFFF_FFFC, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0000, 32'h0000_4444, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0102, 32'h0000_5555, 32'h0000_0100, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_6666, 32'h0000_0104, 1'b1};
    tick();
    tick();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_if_id_pc", if_id_pc, 32'h0);
    chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    ack(32'h0050_0093);
    chk("done_busy", {31'b0, fetch_busy}, 32'd0);
    chk("done_valid", {31'b0, if_id_valid}, 32'd0);
    if_id_wren = 1'b1;
    tick();
    if_id_wren = 1'b0;
    chk("first_instr", if_id_instr, 32'h0050_0093);
    chk("first_if_id_pc", if_id_pc, 32'h0);
    chk("first_valid", {31'b0, if_id_valid}, 32'd1);
    ack(32'hBAD0_BAD0);
    chk("idle_ack_busy", {31'b0, fetch_busy}, 32'd0);
    chk("idle_ack_instr", if_id_instr, 32'h0050_0093);
    if_id_wren = 1'b1;
    tick();
    if_id_wren = 1'b0;
    chk("idle_bubble", {31'b0, if_id_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      wb(vecs[i].taken, vecs[i].target);
      chk($sformatf("vec%0d_pc", i), pc_out, vecs[i].exp_pc);
      chk($sformatf("vec%0d_err", i), {31'b0, fetch_err}, {31'b0, vecs[i].exp_err});
      wait_busy();
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_pc);
      ack(vecs[i].data);
      if_id_wren = 1'b1;
      tick();
      if_id_wren = 1'b0;
      chk($sformatf("vec%0d_instr", i), if_id_instr, vecs[i].data);
      chk($sformatf("vec%0d_if_id_pc", i), if_id_pc, vecs[i].exp_pc);
    end
    stage_reset_n = 1'b0;
    tick();
    stage_reset_n = 1'b1;
    chk("soft_err_kept", {31'b0, fetch_err}, 32'd1);
    chk("soft_pc", pc_out, 32'h0);
    chk("soft_instr", if_id_instr, NOP);
    chk("soft_valid", {31'b0, if_id_valid}, 32'd0);
    wait_busy();
    if_id_wren = 1'b1;
    tick();
    if_id_wren = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("late_valid%0d", i), {31'b0, if_id_valid}, 32'd0);
      chk($sformatf("late_busy%0d", i), {31'b0, fetch_busy}, 32'd1);
      if (i < 4) tick();
    end
    ack(32'h00A0_0113);
    chk("late_instr", if_id_instr, 32'h00A0_0113);
    chk("late_pc", if_id_pc, 32'h0);
    chk("late_valid", {31'b0, if_id_valid}, 32'd1);
    chk("late_idle", {31'b0, fetch_busy}, 32'd0);
    wb(1'b1, 32'h20);
    wait_busy();
    chk("stale_addr0", imem_addr, 32'h20);
    wb(1'b1, 32'h40);
    chk("stale_busy", {31'b0, fetch_busy}, 32'd1);
    ack(32'hDEAD_BEEF);
    chk("stale_refetch", {31'b0, fetch_busy}, 32'd1);
    chk("stale_addr1", imem_addr, 32'h40);
    chk("stale_dropped", if_id_instr, 32'h00A0_0113);
    ack(32'hCAFE_0001);
    if_id_wren = 1'b1;
    tick();
    if_id_wren = 1'b0;
    chk("stale_new_instr", if_id_instr, 32'hCAFE_0001);
    chk("stale_new_pc", if_id_pc, 32'h40);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("hard_err_clear", {31'b0, fetch_err}, 32'd0);
    pc_m = 32'h0;
    err_m = 1'b0;
    for (int it = 0; it < 40; it++) begin
      wait_busy();
      chk($sformatf("rnd%0d_addr", it), imem_addr, pc_m);
      late = 1'($urandom_range(0, 1));
      data = $urandom;
      old_pc = pc_m;
      combo = 1'b0;
      if (late) begin
        if_id_wren = 1'b1;
        tick();
        if_id_wren = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        ack(data);
      end else begin
        repeat ($urandom_range(0, 3)) tick();
        ack(data);
        repeat ($urandom_range(0, 2)) tick();
        combo = 1'($urandom_range(0, 1));
      end
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      taken = 1'($urandom_range(0, 1));
      if (!late) begin
        if_id_wren = 1'b1;
        if (combo) begin
          wb_if_wren = 1'b1;
          branch_taken = taken;
          branch_target = tgt;
        end
        tick();
        if_id_wren = 1'b0;
        wb_if_wren = 1'b0;
        branch_taken = 1'b0;
      end
      chk($sformatf("rnd%0d_instr", it), if_id_instr, data);
      chk($sformatf("rnd%0d_if_id_pc", it), if_id_pc, old_pc);
      chk($sformatf("rnd%0d_valid", it), {31'b0, if_id_valid}, 32'd1);
      if (!combo) wb(taken, tgt);
      pc_m = taken ? (tgt & 32'hFFFF_FFFC) : pc_m + 32'd4;
      err_m = err_m | (taken && tgt[1:0] != 2'b00);
      chk($sformatf("rnd%0d_pc", it), pc_out, pc_m);
      chk($sformatf("rnd%0d_err", it), {31'b0, fetch_err}, {31'b0, err_m});
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    n = 0;
    while (imem_req && n < 300) begin
      n++;
      tick();
    end
`ifdef FETCH_TIMEOUT_EN
    chk("timeout_cycles", 32'(n), 32'd8);
    chk("timeout_err", {31'b0, fetch_err}, 32'd1);
    if_id_wren = 1'b1;
    tick();
    if_id_wren = 1'b0;
    chk("timeout_instr", if_id_instr, NOP);
    chk("timeout_valid", {31'b0, if_id_valid}, 32'd1);
`else
    chk("no_timeout_cycles", 32'(n), 32'd300);
    chk("no_timeout_err", {31'b0, fetch_err}, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
